video_timing_gen: RTL
=====================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, meaning horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, meaning horizontal sync width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, meaning horizontal back porch in pixels.
REQ-005 The block SHALL have parameters V_ACTIVE, V_FP, V_SYNC and V_BP, defaults 480, 10, 2 and 33, meaning the same four quantities in lines.
REQ-006 The block SHALL have parameters HS_POL and VS_POL, default 0 each, where 0 means the sync output is low while asserted.
REQ-007 The block SHALL have port pix_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 The block SHALL have port en, input, 1 bit: advance enable; when low, all state holds.
REQ-010 The block SHALL have port de, output, 1 bit: data enable, high during active pixels.
REQ-011 The block SHALL have port control, output, 2 bits: {vsync, hsync} after polarity, for the TMDS encoder control input.
REQ-012 The block SHALL have ports x and y, output, 12 bits each: active-area pixel coordinate, valid when de is 1.
REQ-013 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse on the first active pixel (0,0).
REQ-014 The block SHALL have port data, output, 24 bits: {R,G,B} test pattern; present only under TEST_PATTERN_EN.

Function
REQ-015 The block SHALL run an h_cnt from 0 to H_TOTAL-1 (H_TOTAL = sum of the H parameters), then wrap to 0.
REQ-016 The block SHALL increment a v_cnt at each h_cnt wrap, running from 0 to V_TOTAL-1 and then wrapping to 0.
REQ-017 The block SHALL decode a horizontal FSM with states H_ACT, H_FRONT, H_SYNC_S and H_BACK, in that order, on h_cnt boundaries H_ACTIVE, +H_FP and +H_SYNC; H_BACK returns to H_ACT on the wrap.
REQ-018 The block SHALL decode a vertical FSM with the same four states on v_cnt boundaries; V state changes only coincident with an h_cnt wrap.
REQ-019 The block SHALL drive de = (H state is H_ACT) AND (V state is V_ACT).
REQ-020 The block SHALL assert hsync iff H state is H_SYNC_S, and vsync iff V state is V_SYNC_S, each XORed with the inverse of its polarity parameter.
REQ-021 The block SHALL register all outputs, with 1 cycle latency from counter state to output; de, control, x, y, data and frame_start SHALL be mutually aligned.
REQ-022 The block SHALL drive x = h_cnt and y = v_cnt during active; outside active, x and y SHALL hold their last active value.
REQ-023 The block SHALL, when en is 0, freeze counters, FSMs and every output at their current value (no pulse stretching of frame_start: it is forced to 0).
REQ-024 The block SHALL use 12-bit counters; the parameter sums SHALL be at most 4096, enforced by an elaboration-time check.

Reset
REQ-025 The block SHALL, with rst high at a clock edge, set h_cnt=0, v_cnt=0, de=0, frame_start=0, x=0, y=0 and data=0, with control at the deasserted-sync level ({~VS_POL,~HS_POL} inverted appropriately, i.e. 2'b11 at default).
REQ-026 The block SHALL treat reset mid-line or mid-frame identically; the first output cycle after release SHALL show pixel (0,0) with de=1 and frame_start=1.
REQ-027 The block SHALL give rst priority over en.

Configuration
REQ-028 The block SHALL, with macro TEST_PATTERN_EN defined, drive data as 8 vertical colour bars of width H_ACTIVE/8 (white, yellow, cyan, green, magenta, red, blue, black), using 0xFF/0x00 channel values, and zero outside active.
REQ-029 The block SHALL, without TEST_PATTERN_EN, omit the data port and its logic entirely.

Structure
REQ-030 The block SHALL take the FSM state encoding typedef, the 640x480 default timing constants and the colour-bar constant table from a shared package, video_timing_pkg.
REQ-031 The block SHALL implement one sub-module, timing_axis_counter, instantiated twice (horizontal and vertical), providing the counter, wrap output and four-state decode.

Verification
REQ-032 Defaults, rst released: first output cycle de=1, x=0, y=0, frame_start=1; de high for exactly 640 consecutive cycles.
REQ-033 Defaults: hsync low for 96 cycles starting 656 cycles after the line's first de; line period 800 cycles; frame period 420000 cycles.
REQ-034 Defaults: vsync low for 2 lines (1600 cycles) starting at line 490; de=0 on all lines 480-524.
REQ-035 en=0 for 10 cycles at h_cnt=100: outputs hold x=100, frame_start=0; after en returns to 1, x=101 on the next cycle.
REQ-036 Assert rst at h_cnt=300, v_cnt=200 for one cycle: next output is (0,0), de=1, frame_start=1.
REQ-037 With TEST_PATTERN_EN: x=0 gives data=FFFFFF, x=80 gives FFFF00, x=639 gives 000000, and blanking gives 000000.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared types and constants for the video timing generator: axis state
// encoding, 640x480@60 default timing and the colour-bar table.
package video_timing_pkg;

    localparam int CNT_W         = 12;
    localparam int CNT_MAX_TOTAL = 4096;

    typedef enum logic [1:0] {
        ST_ACT   = 2'd0,
        ST_FRONT = 2'd1,
        ST_SYNC  = 2'd2,
        ST_BACK  = 2'd3
    } axis_state_t;

    // Axis-specific names for the shared encoding
    localparam axis_state_t H_ACT    = ST_ACT;
    localparam axis_state_t H_FRONT  = ST_FRONT;
    localparam axis_state_t H_SYNC_S = ST_SYNC;
    localparam axis_state_t H_BACK   = ST_BACK;
    localparam axis_state_t V_ACT    = ST_ACT;
    localparam axis_state_t V_FRONT  = ST_FRONT;
    localparam axis_state_t V_SYNC_S = ST_SYNC;
    localparam axis_state_t V_BACK   = ST_BACK;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Index 0 is the leftmost bar
    localparam logic [0:7][23:0] BAR_COLORS = {
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/timing_axis_counter.sv
// One timing axis: wrapping position counter plus active/front/sync/back
// state decode. The state moves in step with the counter.
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output axis_state_t      state
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] END_ACT  = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] END_FP   = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] END_SYNC = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);

    if (TOTAL > CNT_MAX_TOTAL) begin : g_total_check
        $error("timing_axis_counter: total %0d exceeds %0d", TOTAL, CNT_MAX_TOTAL);
    end

    logic [CNT_W-1:0] cnt_nxt;
    axis_state_t      state_nxt;

    assign wrap = step && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            state <= ST_ACT;
        end else begin
            cnt   <= cnt_nxt;
            state <= state_nxt;
        end
    end

    always_comb begin
        cnt_nxt   = cnt;
        state_nxt = state;
        if (step) begin
            cnt_nxt = wrap ? '0 : cnt + 1'b1;
            case (state)
                ST_ACT:   if (cnt == END_ACT)  state_nxt = ST_FRONT;
                ST_FRONT: if (cnt == END_FP)   state_nxt = ST_SYNC;
                ST_SYNC:  if (cnt == END_SYNC) state_nxt = ST_BACK;
                ST_BACK:  if (cnt == LAST)     state_nxt = ST_ACT;
                default:  state_nxt = ST_ACT;
            endcase
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with registered de/sync/coordinate outputs.
// Define TEST_PATTERN_EN to add the 24-bit colour-bar data output.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic             pix_clk,
    input  logic             rst,
    input  logic             en,
    output logic             de,
    output logic [1:0]       control,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_start
`ifdef TEST_PATTERN_EN
    ,
    output logic [23:0]      data
`endif
);

    localparam logic [1:0] CTRL_IDLE = {~VS_POL, ~HS_POL};

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_wrap, v_wrap_unused;
    axis_state_t      h_state, v_state;
    logic             act, hs, vs;

    timing_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h (
        .clk(pix_clk), .rst(rst), .step(en),
        .cnt(h_cnt), .wrap(h_wrap), .state(h_state)
    );

    // Vertical axis only advances on the horizontal wrap
    timing_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v (
        .clk(pix_clk), .rst(rst), .step(h_wrap),
        .cnt(v_cnt), .wrap(v_wrap_unused), .state(v_state)
    );

    assign act = (h_state == H_ACT) && (v_state == V_ACT);
    assign hs  = (h_state == H_SYNC_S) ^ ~HS_POL;
    assign vs  = (v_state == V_SYNC_S) ^ ~VS_POL;

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            de          <= 1'b0;
            control     <= CTRL_IDLE;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else if (en) begin
            de          <= act;
            control     <= {vs, hs};
            frame_start <= act && (h_cnt == '0) && (v_cnt == '0);
            if (act) begin
                x <= h_cnt;
                y <= v_cnt;
            end
        end else begin
            frame_start <= 1'b0;
        end
    end

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [CNT_W-1:0] bar_idx;
    logic [23:0]      bar_color;

    always_comb begin
        bar_idx   = h_cnt / CNT_W'(BAR_W);
        bar_color = (bar_idx > CNT_W'(7)) ? BAR_COLORS[7] : BAR_COLORS[bar_idx[2:0]];
    end

    always_ff @(posedge pix_clk) begin
        if (rst)     data <= '0;
        else if (en) data <= act ? bar_color : 24'h000000;
    end
`endif

endmodule
